// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue: PC steering, in-order imem requests, tagged instruction buffer
module ifetch_queue #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_q,
    output logic                   pc_load,
    output logic                   pc_inc,
    output logic                   pc_stall,
    output logic [PC_WIDTH-1:0]    pc_next,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_WIDTH-1:0]    addr_q [DEPTH];
    logic [INSTR_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]       filled_q, filled_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    // pend_cnt tracks allocated-but-unfilled slots so a redirect knows how many
    // in-flight responses it must later discard.
    logic [CNT_W-1:0]       alloc_cnt_q, alloc_cnt_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]       pend_cnt_q, pend_cnt_d;
    logic [CNT_W:0]         occ;
    logic                   fire, pop, fill_rsp, drop_rsp;

    assign occ            = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign imem_req_valid = !rst && !redirect_valid && (occ < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid && imem_req_ready;
    assign drop_rsp       = imem_rsp_valid && (drop_cnt_q != '0);
    assign fill_rsp       = imem_rsp_valid && (drop_cnt_q == '0);

    assign pc_load  = redirect_valid && !rst;
    assign pc_inc   = fire;
    assign pc_stall = !pc_load && !pc_inc;
    assign pc_next  = redirect_pc;

    assign instr_valid = !rst && !redirect_valid && filled_q[head_q];
    assign instr_data  = data_q[head_q];
    assign instr_pc    = addr_q[head_q];
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        filled_d    = filled_q;
        alloc_cnt_d = alloc_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        pend_cnt_d  = pend_cnt_q;
        if (redirect_valid) begin
            // A response landing this cycle is charged against the flushed work.
            head_d      = '0;
            tail_d      = '0;
            fill_d      = '0;
            filled_d    = '0;
            alloc_cnt_d = '0;
            pend_cnt_d  = '0;
            drop_cnt_d  = drop_cnt_q + pend_cnt_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (fire) begin
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + 1'b1;
            end
            if (fill_rsp) begin
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + 1'b1;
            end
            if (drop_rsp) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + 1'b1;
            end
            alloc_cnt_d = alloc_cnt_q + CNT_W'(fire) - CNT_W'(pop);
            pend_cnt_d  = pend_cnt_q + CNT_W'(fire) - CNT_W'(fill_rsp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            filled_q    <= '0;
            alloc_cnt_q <= '0;
            drop_cnt_q  <= '0;
            pend_cnt_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            filled_q    <= filled_d;
            alloc_cnt_q <= alloc_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            pend_cnt_q  <= pend_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            addr_q[tail_q] <= pc_q;
        end
        if (fill_rsp && !redirect_valid && !rst) begin
            data_q[fill_q] <= imem_rsp_data;
        end
    end

    // A response must always have a flushed request or an unfilled slot to land on.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && drop_cnt_q == '0 && pend_cnt_q == '0));
        end
    end
endmodule
